// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time, period and tenths-scale duty of an incoming PWM signal,
// with timeout reporting of stuck-high / stuck-low levels.
module pwm_decoder #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_count,
   output logic [CNT_W-1:0] period_count,
   output logic [3:0]       duty,
   output logic             valid,
   output logic             stuck_hi,
   output logic             stuck_lo,
   output logic             overrun
);
   localparam int AW = CNT_W + 4;
   localparam int IW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t state, state_n;
   logic s1, s2, prev, rise, fall, tog, tmo, snap, busy, done, fit, pend, pend_lvl, lvl;
   logic [CNT_W-1:0] cnt, h_lat, hd, pd;
   logic [IW-1:0] idle;
   logic [AW-1:0] acc, sum;
   logic [3:0] step, k;
   assign rise = s2 & ~prev;
   assign fall = ~s2 & prev;
   assign tog  = s2 ^ prev;
   assign tmo  = ~tog & (idle == IW'(TIMEOUT - 1));
   assign sum  = acc + AW'(pd);
   assign fit  = sum <= AW'(hd) * AW'(10);
   assign done = busy & (step == 4'd9);
   assign lvl  = pend ? pend_lvl : s2;
   always_comb begin
      state_n = state;
      snap    = 1'b0;
      if (tmo)
         state_n = IDLE;
      else
         unique case (state)
            IDLE:    state_n = rise ? HIGH : IDLE;
            HIGH:    state_n = fall ? LOW : HIGH;
            LOW: begin
               state_n = rise ? HIGH : LOW;
               snap    = rise;
            end
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         prev  <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         h_lat <= '0;
         idle  <= '0;
      end else begin
         s1    <= pwm_in;
         s2    <= s1;
         prev  <= s2;
         state <= state_n;
         cnt   <= rise ? CNT_W'(1) : (cnt == '1 ? cnt : cnt + 1'b1);
         if (state == HIGH && fall) h_lat <= cnt;
         idle  <= tog ? '0 : (idle == IW'(TIMEOUT) ? idle : idle + 1'b1);
      end
   end
   // Divider runs exactly 10 compare steps; a completion takes priority over a timeout, which is deferred by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy         <= 1'b0;
         step         <= '0;
         acc          <= '0;
         k            <= '0;
         hd           <= '0;
         pd           <= '0;
         pend         <= 1'b0;
         pend_lvl     <= 1'b0;
         high_count   <= '0;
         period_count <= '0;
         duty         <= '0;
         valid        <= 1'b0;
         stuck_hi     <= 1'b0;
         stuck_lo     <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (snap & ~busy) begin
            busy <= 1'b1;
            step <= '0;
            acc  <= '0;
            k    <= '0;
            hd   <= h_lat;
            pd   <= cnt;
         end else if (busy) begin
            step <= step + 4'd1;
            if (fit) begin
               acc <= sum;
               k   <= k + 4'd1;
            end
            if (done) busy <= 1'b0;
         end
         if (snap & busy) overrun <= 1'b1;
         pend     <= tmo & done;
         pend_lvl <= s2;
         valid    <= 1'b0;
         if (tog) begin
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
         end
         if (done) begin
            valid        <= 1'b1;
            duty         <= k + 4'(fit);
            high_count   <= hd;
            period_count <= pd;
         end else if (tmo | pend) begin
            valid        <= 1'b1;
            duty         <= lvl ? 4'd10 : 4'd0;
            high_count   <= '0;
            period_count <= '0;
            stuck_hi     <= lvl;
            stuck_lo     <= ~lvl;
         end
      end
   end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed checks of pwm_decoder with hand-computed expected results.
module tb_pwm_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pwm_in = 1'b0;
   logic [15:0] high_count, period_count;
   logic [3:0]  duty;
   logic        valid, stuck_hi, stuck_lo, overrun;
   int checks = 0, errors = 0;
   int cyc = 0, nvalid = 0, nstuck = 0, vcyc = 0, rise_cyc = 0;
   int hc_q = 0, pc_q = 0, du_q = 0, sh_q = 0, sl_q = 0;

   pwm_decoder #(.CNT_W(16), .TIMEOUT(1000)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_count(high_count),
      .period_count(period_count), .duty(duty), .valid(valid),
      .stuck_hi(stuck_hi), .stuck_lo(stuck_lo), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (valid) begin
      nvalid = nvalid + 1;
      if (stuck_hi) nstuck = nstuck + 1;
      vcyc = cyc; hc_q = high_count; pc_q = period_count; du_q = duty;
      sh_q = stuck_hi; sl_q = stuck_lo;
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wave(input int h, input int p, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = 1'b1;
         rise_cyc = cyc;
         hold(h);
         pwm_in = 1'b0;
         hold(p - h);
      end
   endtask

   task automatic test_reset;
      hold(3);
      checks += 7;
      if (high_count !== 16'd0) begin errors++; $display("FAIL reset_hc: got %0d want 0", high_count); end
      if (period_count !== 16'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", period_count); end
      if (duty !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
      if (stuck_hi !== 1'b0) begin errors++; $display("FAIL reset_sh: got %0b want 0", stuck_hi); end
      if (stuck_lo !== 1'b0) begin errors++; $display("FAIL reset_sl: got %0b want 0", stuck_lo); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b want 0", overrun); end
      rst = 1'b1;
      hold(1);
   endtask

   task automatic test_square;
      int nv0, r2;
      nv0 = nvalid;
      wave(50, 100, 1);
      checks++;
      if (nvalid !== nv0) begin errors++; $display("FAIL sq_first_rise: got %0d valids want %0d", nvalid, nv0); end
      wave(50, 100, 1);
      r2 = rise_cyc;
      checks += 5;
      if (nvalid !== nv0 + 1) begin errors++; $display("FAIL sq_count1: got %0d want %0d", nvalid, nv0 + 1); end
      if (vcyc - r2 !== 13) begin errors++; $display("FAIL sq_latency: got %0d want 13", vcyc - r2); end
      if (hc_q !== 50) begin errors++; $display("FAIL sq_hc: got %0d want 50", hc_q); end
      if (pc_q !== 100) begin errors++; $display("FAIL sq_pc: got %0d want 100", pc_q); end
      if (du_q !== 5) begin errors++; $display("FAIL sq_duty: got %0d want 5", du_q); end
      wave(50, 100, 3);
      checks += 3;
      if (nvalid !== nv0 + 4) begin errors++; $display("FAIL sq_count4: got %0d want %0d", nvalid, nv0 + 4); end
      if (vcyc - rise_cyc !== 13) begin errors++; $display("FAIL sq_latency_rep: got %0d want 13", vcyc - rise_cyc); end
      if (du_q !== 5 || hc_q !== 50 || pc_q !== 100) begin errors++; $display("FAIL sq_rep: got %0d/%0d/%0d want 50/100/5", hc_q, pc_q, du_q); end
   endtask

   task automatic test_sweep;
      for (int d = 1; d <= 9; d++) begin
         wave(10 * d, 100, 2);
         checks++;
         if (du_q !== d || hc_q !== 10 * d || pc_q !== 100)
            begin errors++; $display("FAIL sweep_d%0d: got %0d/%0d/%0d want %0d/100/%0d", d, hc_q, pc_q, du_q, 10 * d, d); end
      end
      pwm_in = 1'b1;
      hold(1100);
      checks += 4;
      if (sh_q !== 1 || sl_q !== 0) begin errors++; $display("FAIL sweep_d10_flags: got sh=%0d sl=%0d want 1/0", sh_q, sl_q); end
      if (du_q !== 10) begin errors++; $display("FAIL sweep_d10_duty: got %0d want 10", du_q); end
      if (hc_q !== 0 || pc_q !== 0) begin errors++; $display("FAIL sweep_d10_counts: got %0d/%0d want 0/0", hc_q, pc_q); end
      if (stuck_hi !== 1'b1) begin errors++; $display("FAIL sweep_d10_live: got %0b want 1", stuck_hi); end
      pwm_in = 1'b0;
      hold(1100);
      checks += 3;
      if (sl_q !== 1 || sh_q !== 0) begin errors++; $display("FAIL sweep_d0_flags: got sh=%0d sl=%0d want 0/1", sh_q, sl_q); end
      if (du_q !== 0) begin errors++; $display("FAIL sweep_d0_duty: got %0d want 0", du_q); end
      if (stuck_hi !== 1'b0 || stuck_lo !== 1'b1) begin errors++; $display("FAIL sweep_d0_live: got sh=%0b sl=%0b want 0/1", stuck_hi, stuck_lo); end
   endtask

   task automatic test_ratio;
      wave(37, 100, 3);
      checks += 2;
      if (du_q !== 3 || hc_q !== 37 || pc_q !== 100) begin errors++; $display("FAIL ratio_37: got %0d/%0d/%0d want 37/100/3", hc_q, pc_q, du_q); end
      if (stuck_lo !== 1'b0) begin errors++; $display("FAIL ratio_sl_clear: got %0b want 0", stuck_lo); end
      wave(99, 100, 2);
      checks++;
      if (du_q !== 9 || hc_q !== 99 || pc_q !== 100) begin errors++; $display("FAIL ratio_99: got %0d/%0d/%0d want 99/100/9", hc_q, pc_q, du_q); end
   endtask

   task automatic test_overrun;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %0b want 0", overrun); end
      wave(4, 8, 6);
      checks += 2;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b want 1", overrun); end
      if (du_q !== 5 || hc_q !== 4 || pc_q !== 8) begin errors++; $display("FAIL ovr_result: got %0d/%0d/%0d want 4/8/5", hc_q, pc_q, du_q); end
   endtask

   task automatic test_stuck_recovery;
      int ns0;
      ns0 = nstuck;
      pwm_in = 1'b1;
      hold(2000);
      checks += 2;
      if (nstuck !== ns0 + 1) begin errors++; $display("FAIL stuck_once: got %0d want %0d", nstuck - ns0, 1); end
      if (stuck_hi !== 1'b1) begin errors++; $display("FAIL stuck_hi_set: got %0b want 1", stuck_hi); end
      hold(30);
      pwm_in = 1'b0;
      hold(5);
      checks++;
      if (stuck_hi !== 1'b0) begin errors++; $display("FAIL stuck_hi_clear: got %0b want 0", stuck_hi); end
      hold(25);
      wave(30, 60, 2);
      checks++;
      if (du_q !== 5 || hc_q !== 30 || pc_q !== 60) begin errors++; $display("FAIL stuck_resume: got %0d/%0d/%0d want 30/60/5", hc_q, pc_q, du_q); end
   endtask

   task automatic test_reset_mid;
      int nv0;
      pwm_in = 1'b1;
      hold(10);
      #3 rst = 1'b0;
      pwm_in = 1'b0;
      #1;
      checks += 4;
      if (high_count !== 16'd0 || period_count !== 16'd0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", high_count, period_count); end
      if (duty !== 4'd0) begin errors++; $display("FAIL rmid_duty: got %0d want 0", duty); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_ovr: got %0b want 0", overrun); end
      if (stuck_hi !== 1'b0 || stuck_lo !== 1'b0) begin errors++; $display("FAIL rmid_stuck: got %0b/%0b want 0/0", stuck_hi, stuck_lo); end
      hold(2);
      rst = 1'b1;
      hold(1);
      nv0 = nvalid;
      wave(20, 50, 1);
      checks++;
      if (nvalid !== nv0) begin errors++; $display("FAIL rmid_one_rise: got %0d valids want %0d", nvalid - nv0, 0); end
      wave(20, 50, 2);
      checks += 2;
      if (nvalid !== nv0 + 2) begin errors++; $display("FAIL rmid_count: got %0d want %0d", nvalid - nv0, 2); end
      if (du_q !== 4 || hc_q !== 20 || pc_q !== 50) begin errors++; $display("FAIL rmid_result: got %0d/%0d/%0d want 20/50/4", hc_q, pc_q, du_q); end
   endtask

   initial begin
      test_reset;
      test_square;
      test_sweep;
      test_ratio;
      test_overrun;
      test_stuck_recovery;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart of the PWM generator: measures an incoming PWM waveform and reports its high time, period, and duty cycle on the generator's 0–10 (tenths) scale. It sits at the board input, after the pin, and feeds status/compare logic. It can close a loopback on the generator's output. Constant-level inputs (0 % / 100 %) are reported through a timeout path.

## Interface
- CNT_W, 16, width of high/period counters
- TIMEOUT, 1000, cycles without an edge before a stuck level is declared (must be < 2^CNT_W)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pwm_in  in  1  asynchronous PWM input
- high_count  out  CNT_W  clk cycles input was high in last full period
- period_count  out  CNT_W  clk cycles between last two rising edges
- duty  out  4  floor(10*high_count/period_count), range 0..10
- valid  out  1  one-cycle pulse when outputs update
- stuck_hi  out  1  input held high ≥ TIMEOUT cycles
- stuck_lo  out  1  input held low ≥ TIMEOUT cycles
- overrun  out  1  sticky; a measurement was dropped because the divider was busy

## Operation
- Input path: 2-FF synchronizer (s1, s2), then prev register. rise = s2 & ~prev; fall = ~s2 & prev.
- Measurement FSM states:
  - IDLE: wait for rise.
  - HIGH: wait for fall.
  - LOW: wait for rise.
- cnt (CNT_W) loads 1 on every rise and otherwise increments. It saturates at all-ones.
- IDLE --rise--> HIGH.
- HIGH --fall--> LOW; latch h_lat = cnt.
- LOW --rise--> HIGH; snapshot (h_lat, cnt) to the divider. Measurement of the next period continues without a gap.
- Timeout: a separate idle counter clears on rise or fall and saturates at TIMEOUT.
  - When it reaches TIMEOUT with s2=1: set stuck_hi, duty=10, high_count=period_count=0, pulse valid, FSM -> IDLE.
  - With s2=0: same, but stuck_lo and duty=0.
  - Fires once per stuck interval.
  - stuck_hi/stuck_lo clear on the next rise or fall.
- Divider: fixed 10-cycle sequential compare.
  - acc=0, k=0.
  - Each cycle: if acc+P ≤ 10*H then acc+=P, k+=1.
  - Internal width CNT_W+4.
  - After 10 cycles: drive duty=k, high_count=H, period_count=P, pulse valid.
- If a snapshot arrives while the divider is busy, drop it and set overrun. overrun clears only on reset.
- If a timeout and a divider completion land in the same cycle, the divider result wins. The timeout valid is issued the next cycle.
- Reset (async, rst=0):
  - FSM IDLE; all counters and registers 0.
  - high_count=0, period_count=0, duty=0.
  - valid=0, stuck_hi=0, stuck_lo=0, overrun=0.
  - Reset mid-measurement discards the partial result. The first valid after reset requires two rises.

## Timing
- Pin-to-detect: a pwm_in transition sampled at clk edge n yields rise/fall in cycle n+2.
- For a clk-synchronous input high H cycles in period P: high_count=H, period_count=P exactly.
- Let E be the cycle where the closing rise is detected. The divider runs E+1..E+10; valid is high in cycle E+11. Outputs change in the same cycle and hold until the next valid.
- Minimum measurable period: 11 cycles. Shorter periods cause overrun drops and no corruption.
- Timeout: valid asserts TIMEOUT cycles after the last detected edge (or after leaving reset if no edge occurred).
- Counter saturation: with P ≥ 2^CNT_W, period_count = 2^CNT_W−1. Duty is computed from the saturated values. TIMEOUT normally fires first.

## Test plan
- Reset: drive rst=0 mid-period -> all outputs 0 immediately. After release, no valid until the second rise.
- Square wave H=50, P=100, repeated -> valid every 100 cycles; high_count=50, period_count=100, duty=5; first valid 11 cycles after the second detected rise.
- Sweep generator duty 0..10 with a 10-cycle-per-step base (P=100, H=10*d):
  - d=1..9 -> duty=d.
  - d=0 -> stuck_lo and duty=0 after TIMEOUT.
  - d=10 -> stuck_hi and duty=10 after TIMEOUT.
- Non-integer ratio H=37, P=100 -> duty=3; H=99, P=100 -> duty=9.
- Period P=8, H=4 -> overrun set on the second snapshot. The accepted result reads high_count=4, period_count=8, duty=5.
- Stuck recovery: hold high 2000 cycles -> one valid with stuck_hi. Resume H=30, P=60 -> stuck_hi clears at fall; the next full period reports duty=5.
